// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle 32-bit signed/unsigned integer divider using a
// non-restoring shift/subtract datapath. A division is accepted in IDLE or
// DONE when start is high. PREP loads the operand magnitudes, ITER runs one
// quotient bit per cycle for WIDTH cycles, and FIX restores the remainder,
// applies the signs and writes the result registers. done is high for the
// single DONE cycle.
//
// Compile-time option:
//   DIV_ZERO_TRAP_EN - when defined, a divisor of zero skips the datapath and
//                      goes straight to DONE, one cycle after the accepting
//                      edge. When undefined, it runs the full sequence. In
//                      both builds the result is quotient=all ones,
//                      remainder=dividend, dz_err=1.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      division request (ignored while busy)
//   is_signed  1 = two's-complement divide, 0 = unsigned divide
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   busy       high in PREP, ITER and FIX
//   done       high in DONE only
//   quotient   registered quotient
//   remainder  registered remainder, which takes the sign of the dividend
//   dz_err     registered divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for start
// PREP  | load magnitudes, clear A and the counter, record the result signs
// ITER  | one non-restoring step per cycle, WIDTH cycles in all
// FIX   | restore the remainder, apply the signs, write the results
// DONE  | results valid; a new start may be accepted here
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_new;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    accept  = start && (state_q == S_IDLE || state_q == S_DONE);

    // Non-restoring step: the sign of A before the shift selects add or subtract.
    a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_new   = a_q[WIDTH] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});

    // A negative final A has gone one subtract too far; adding M back restores it.
    r_mag   = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];
    q_fix   = qneg_q ? (~q_q + 1'b1) : q_q;
    r_fix   = (rneg_q && r_mag != '0) ? (~r_mag + 1'b1) : r_mag;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PREP;
      end
      S_PREP: begin
        // Negating the most negative value leaves 1000...0, which read as
        // unsigned is the correct magnitude.
        q_d     = (sgn_q && op_a_q[WIDTH-1]) ? (~op_a_q + 1'b1) : op_a_q;
        m_d     = (sgn_q && op_b_q[WIDTH-1]) ? (~op_b_q + 1'b1) : op_b_q;
        a_d     = '0;
        cnt_d   = '0;
        qneg_d  = sgn_q && (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]);
        rneg_d  = sgn_q && op_a_q[WIDTH-1];
        state_d = S_ITER;
      end
      S_ITER: begin
        a_d = a_new;
        q_d = {q_q[WIDTH-2:0], ~a_new[WIDTH]};
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_FIX: begin
        if (op_b_q == '0) begin
          quot_d = '1;
          rem_d  = op_a_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_fix;
          rem_d  = r_fix;
          dz_d   = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start ? S_PREP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_a_d = dividend;
      op_b_d = divisor;
      sgn_d  = is_signed;
    end

`ifdef DIV_ZERO_TRAP_EN
    // A zero divisor needs no datapath work: write the trap result now and go
    // straight to DONE.
    if (accept && divisor == '0) begin
      quot_d  = '1;
      rem_d   = dividend;
      dz_d    = 1'b1;
      state_d = S_DONE;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz_err    = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl. Expected results come from plain
// 64-bit integer division, with the divide-by-zero rule applied on top.
// The expected latency, counted from the accepting edge to the first
// sample in which done is high, depends on whether DIV_ZERO_TRAP_EN is set.
module tb_div_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dz_err;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_err    (dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint sa, sb;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dz  = 1'b1;
      lat = TRAP ? 1 : 35;
    end else begin
      dz  = 1'b0;
      lat = 35;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end else begin
        q  = a / b;
        r  = a % b;
      end
    end
  endfunction

  // Presents an operation and returns just after its accepting edge, with the
  // inputs already scrambled so that late changes would show up in the result.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  // Samples at each falling edge until done is seen, or gives up after 100
  // samples. If pulse_at is nonzero, start is pulsed with junk operands
  // right after that sample.
  task automatic wait_done(input string tag, input int exp_lat, input int pulse_at, output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, 32'(busy), 32'(exp_lat > 1));
      if (done) seen = 1'b1;
      if (!seen && n == pulse_at) begin
        start     = 1'b1;
        dividend  = $urandom;
        divisor   = $urandom_range(1, 100);
        is_signed = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int pulse_at);
    logic [31:0] eq, er;
    logic        edz;
    int          elat, n;
    model(a, b, s, eq, er, edz, elat);
    start_op(a, b, s);
    wait_done(tag, elat, pulse_at, n);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, 32'(dz_err), 32'(edz));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, quotient, eq);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        s, edz;
    int          elat, n;
    bit          seen;

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(dz_err), 32'd0);
    reset = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("dz_1234", 32'h0000_1234, 32'd0, 1'b0, 0);
    run_op("u_clr_dz", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("s_dz", 32'h8000_0000, 32'd0, 1'b1, 0);
    run_op("u_small", 32'd3, 32'd10, 1'b0, 0);
    run_op("s_pos_neg", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      run_op("rand", a, b, s, 0);
    end

    run_op("ign_start", 32'd1000, 32'd33, 1'b0, 5);
    run_op("ign_start_s", 32'hFFFF_F000, 32'd77, 1'b1, 20);

    // Reset arrives during ITER: the operation is abandoned and the previous
    // nonzero result is cleared.
    start_op(32'd999, 32'd5, 1'b0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_dz", 32'(dz_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mid_rst_nodone", 32'(seen), 32'd0);
    run_op("post_rst", 32'd12345, 32'd11, 1'b0, 0);

    // Back-to-back: start is held into DONE with new operands.
    model(32'd5000, 32'd9, 1'b0, eq, er, edz, elat);
    start_op(32'd5000, 32'd9, 1'b0);
    wait_done("b2b1", elat, 0, n);
    chk("b2b1_lat", 32'(n), 32'(elat));
    chk("b2b1_q", quotient, eq);
    chk("b2b1_r", remainder, er);
    dividend  = 32'hFFFF_FF00;
    divisor   = 32'd3;
    is_signed = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    model(32'hFFFF_FF00, 32'd3, 1'b1, eq, er, edz, elat);
    wait_done("b2b2", elat, 0, n);
    chk("b2b2_lat", 32'(n), 32'(elat));
    chk("b2b2_q", quotient, eq);
    chk("b2b2_r", remainder, er);
    chk("b2b2_dz", 32'(dz_err), 32'(edz));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width. Legal value is 32 only; the counter is sized to hold WIDTH-1.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request a division. Sampled on clk.
REQ-005 Port is_signed, input, 1: 1 = two's-complement divide, 0 = unsigned divide. Sampled with start.
REQ-006 Port dividend, input, WIDTH: numerator. Sampled with start.
REQ-007 Port divisor, input, WIDTH: denominator. Sampled with start.
REQ-008 Port busy, output, 1: high while an operation is in progress.
REQ-009 Port done, output, 1: one-cycle pulse marking valid results.
REQ-010 Port quotient, output, WIDTH: LO result, registered.
REQ-011 Port remainder, output, WIDTH: HI result, registered.
REQ-012 Port dz_err, output, 1: divide-by-zero flag, registered.

Function
REQ-013 The FSM SHALL have five states: IDLE, PREP, ITER, FIX, DONE.
REQ-014 Transitions:
- IDLE->PREP on start=1.
- PREP->ITER unconditionally.
- ITER->FIX after WIDTH ITER cycles.
- FIX->DONE unconditionally.
- DONE->PREP if start=1, else DONE->IDLE.
REQ-015 On the accepting edge, the block SHALL latch dividend, divisor and is_signed; later input changes SHALL NOT affect the operation.
REQ-016 start SHALL be ignored in PREP, ITER and FIX. There is no queuing.
REQ-017 PREP SHALL do all of the following:
- load the magnitudes of the operands (absolute value when is_signed=1, raw otherwise);
- clear the partial remainder A (WIDTH+1 bits);
- clear the iteration counter;
- record the quotient sign (sign XOR) and the remainder sign (dividend sign).
REQ-018 Each ITER cycle SHALL perform one non-restoring step:
- shift {A,Q} left 1;
- if A was non-negative before the shift, A=A-M, else A=A+M;
- set Q[0] = ~A_new[sign].
REQ-019 FIX SHALL do all of the following:
- add M to A if A is negative (remainder restore);
- negate the quotient if the quotient sign is set;
- negate the remainder if the remainder sign is set and the remainder is nonzero;
- write the quotient and remainder registers.
REQ-020 busy SHALL be 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 only in DONE. It asserts exactly WIDTH+3 cycles after the accepting edge (35 cycles for WIDTH=32).
REQ-022 Signed results SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient=0x80000000 and remainder=0, with no error flag.
REQ-024 quotient, remainder and dz_err SHALL hold their values from DONE until the next FIX or reset.
REQ-025 dz_err SHALL be set when a result is written with divisor=0, and cleared when a result is written with divisor!=0.

Reset
REQ-026 reset SHALL take effect asynchronously in any state, including mid-ITER, and force:
- FSM = IDLE;
- busy, done and dz_err = 0;
- quotient, remainder, A, Q, M and the counter = 0.
REQ-027 No done SHALL be produced for an operation aborted by reset. The first accepting edge after reset release starts a fresh operation.

Configuration
REQ-028 The macro DIV_ZERO_TRAP_EN SHALL control divide-by-zero handling.
- Defined: a start with divisor=0 goes IDLE/DONE->DONE directly, producing done 1 cycle after the accepting edge, with quotient=0xFFFFFFFF, remainder=dividend and dz_err=1. busy stays 0.
- Undefined: divisor=0 runs the full WIDTH+3-cycle sequence. Outputs are still forced to quotient=0xFFFFFFFF, remainder=dividend, dz_err=1.

Verification
REQ-029 Unsigned 100/7:
- start -> done at cycle 35, quotient=14, remainder=2, dz_err=0.
REQ-030 Signed -7/2 (0xFFFFFFF9 / 0x00000002):
- -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF:
- -> quotient=0x80000000, remainder=0, dz_err=0.
REQ-032 Divisor=0, dividend=0x1234:
- -> quotient=0xFFFFFFFF, remainder=0x1234, dz_err=1;
- done at cycle 1 with DIV_ZERO_TRAP_EN, at cycle 35 without.
REQ-033 Reset and ignored start:
- reset asserted at ITER cycle 10 -> busy=0, outputs=0, no done pulse;
- start pulsed while busy with different operands -> ignored, original result unchanged.
REQ-034 Back-to-back operation:
- start held high in DONE -> new operation accepted, next done 35 cycles later.
